// File: rtl/shift_pkg.sv
// rtl/shift_pkg.sv - shared shift codes, amount limit and entry field widths
// Purpose: constants shared by the issue stage, its amount normaliser and the
// surrounding datapath. No ports.
package shift_pkg;

  localparam logic [2:0] SH_ROL = 3'b000;
  localparam logic [2:0] SH_ROR = 3'b001;
  localparam logic [2:0] SH_ASR = 3'b010;
  localparam logic [2:0] SH_LSL = 3'b011;
  localparam logic [2:0] SH_LSR = 3'b100;

  // Largest amount the shifter accepts for the non-rotating codes.
  localparam logic [4:0] SH_MAX_AMT = 5'd8;

  // Entry layout widths.
  localparam int DATA_W = 8;
  localparam int RAW_W  = 8;
  localparam int IMM_W  = 5;
  localparam int AMT_W  = 5;
  localparam int TYPE_W = 3;

endpackage

// File: rtl/shift_issue_stage_if.sv
// rtl/shift_issue_stage_if.sv - request and shifter-side handshake bundle
// Purpose: groups the upstream request channel (req_*) and the downstream
// shifter channel (sh_*) of the issue stage.
// Modports:
//   slave  - the issue stage: takes req_*, drives req_ready, drives sh_*, takes sh_ready
//   master - the environment: drives req_*, takes req_ready, takes sh_*, drives sh_ready
interface shift_issue_stage_if #(parameter int TAG_W = 3);
  import shift_pkg::*;

  logic                req_valid;
  logic                req_ready;
  logic [DATA_W-1:0]   req_data;
  logic [TYPE_W-1:0]   req_type;
  logic                req_amt_sel;
  logic [IMM_W-1:0]    req_amt_imm;
  logic [RAW_W-1:0]    req_amt_reg;
  logic [TAG_W-1:0]    req_tag;

  logic                sh_valid;
  logic                sh_ready;
  logic [DATA_W-1:0]   sh_in;
  logic [AMT_W-1:0]    sh_amount;
  logic [TYPE_W-1:0]   sh_type;
  logic [TAG_W-1:0]    sh_tag;

  modport slave (
    input  req_valid, req_data, req_type, req_amt_sel, req_amt_imm, req_amt_reg, req_tag,
    output req_ready,
    output sh_valid, sh_in, sh_amount, sh_type, sh_tag,
    input  sh_ready
  );

  modport master (
    output req_valid, req_data, req_type, req_amt_sel, req_amt_imm, req_amt_reg, req_tag,
    input  req_ready,
    input  sh_valid, sh_in, sh_amount, sh_type, sh_tag,
    output sh_ready
  );

endinterface

// File: rtl/shift_amt_norm.sv
// rtl/shift_amt_norm.sv - maps a raw 8-bit shift amount to the shifter's 5-bit amount
// Purpose: rotates keep raw mod 8, arithmetic/logical shifts saturate at 8,
// unknown codes get amount 0.
// Ports:
//   raw_i  in  8  raw amount (immediate zero-extended or register value)
//   type_i in  3  shift code
//   amt_o  out 5  normalised amount
module shift_amt_norm
  import shift_pkg::*;
(
  input  logic [RAW_W-1:0]  raw_i,
  input  logic [TYPE_W-1:0] type_i,
  output logic [AMT_W-1:0]  amt_o
);

  always_comb begin
    amt_o = '0;
    case (type_i)
      SH_ROL, SH_ROR:         amt_o = {2'b00, raw_i[2:0]};
      SH_ASR, SH_LSL, SH_LSR: amt_o = (raw_i > RAW_W'(SH_MAX_AMT)) ? SH_MAX_AMT
                                                                   : raw_i[AMT_W-1:0];
      default:                amt_o = '0;
    endcase
  end

endmodule

// File: rtl/shift_issue_stage.sv
// rtl/shift_issue_stage.sv - buffers normalised shift requests ahead of the rotate/shift unit
// Purpose: accepts decoded shift requests, normalises the amount, holds up to
// DEPTH requests in a circular buffer and presents the head to the shifter.
// Ports:
//   clk   in   1              rising-edge clock
//   reset in   1              asynchronous active-high reset
//   flush in   1              synchronous discard of all buffered requests
//   bus   slave               req_* request channel and sh_* shifter channel
//   count out  $clog2(DEPTH)+1 occupancy
module shift_issue_stage
  import shift_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int TAG_W = 3
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   flush,
  shift_issue_stage_if.slave     bus,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [DATA_W-1:0] data_q [DEPTH];
  logic [AMT_W-1:0]  amt_q  [DEPTH];
  logic [TYPE_W-1:0] type_q [DEPTH];
  logic [TAG_W-1:0]  tag_q  [DEPTH];

  logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              ready_q;

  // Last popped entry, shown on sh_* while the buffer is empty.
  logic [DATA_W-1:0] last_data_q;
  logic [AMT_W-1:0]  last_amt_q;
  logic [TYPE_W-1:0] last_type_q;
  logic [TAG_W-1:0]  last_tag_q;

  logic [RAW_W-1:0]  raw_amt;
  logic [AMT_W-1:0]  norm_amt;
  logic              head_valid, push, pop;

  assign raw_amt = bus.req_amt_sel ? bus.req_amt_reg
                                   : {{(RAW_W-IMM_W){1'b0}}, bus.req_amt_imm};

  shift_amt_norm u_norm (
    .raw_i  (raw_amt),
    .type_i (bus.req_type),
    .amt_o  (norm_amt)
  );

  assign head_valid = (count_q != '0);
  // ready_q is already low when full, so a same-cycle pop never frees a slot for a push.
  assign push = bus.req_valid & ready_q & ~flush;
  assign pop  = head_valid & bus.sh_ready & ~flush;

  always_comb begin
    count_d = count_q;
    if (flush)            count_d = '0;
    else if (push & ~pop) count_d = count_q + CNT_W'(1);
    else if (pop & ~push) count_d = count_q - CNT_W'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        data_q[i] <= '0;
        amt_q[i]  <= '0;
        type_q[i] <= '0;
        tag_q[i]  <= '0;
      end
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      ready_q     <= 1'b0;
      last_data_q <= '0;
      last_amt_q  <= '0;
      last_type_q <= '0;
      last_tag_q  <= '0;
    end else begin
      count_q <= count_d;
      ready_q <= (count_d < CNT_W'(DEPTH));
      if (flush) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
      end else begin
        if (push) begin
          data_q[wr_ptr_q] <= bus.req_data;
          amt_q[wr_ptr_q]  <= norm_amt;
          type_q[wr_ptr_q] <= bus.req_type;
          tag_q[wr_ptr_q]  <= bus.req_tag;
          wr_ptr_q         <= wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
          last_data_q <= data_q[rd_ptr_q];
          last_amt_q  <= amt_q[rd_ptr_q];
          last_type_q <= type_q[rd_ptr_q];
          last_tag_q  <= tag_q[rd_ptr_q];
          rd_ptr_q    <= rd_ptr_q + PTR_W'(1);
        end
      end
    end
  end

  assign bus.req_ready = ready_q;
  assign bus.sh_valid  = head_valid;
  assign bus.sh_in     = head_valid ? data_q[rd_ptr_q] : last_data_q;
  assign bus.sh_amount = head_valid ? amt_q[rd_ptr_q]  : last_amt_q;
  assign bus.sh_type   = head_valid ? type_q[rd_ptr_q] : last_type_q;
  assign bus.sh_tag    = head_valid ? tag_q[rd_ptr_q]  : last_tag_q;
  assign count         = count_q;

endmodule

// File: tb/tb_shift_issue_stage.sv
// tb/tb_shift_issue_stage.sv - scoreboard bench for shift_issue_stage
module tb_shift_issue_stage;

  localparam int DEPTH = 2;
  localparam int TAG_W = 3;

  typedef struct {
    int data;
    int amt;
    int typ;
    int tag;
  } exp_t;

  logic       clk   = 1'b0;
  logic       reset = 1'b1;
  logic       flush = 1'b0;
  logic [1:0] count;

  shift_issue_stage_if #(.TAG_W(TAG_W)) bus ();

  shift_issue_stage #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
    .clk   (clk),
    .reset (reset),
    .flush (flush),
    .bus   (bus),
    .count (count)
  );

  always #5 clk = ~clk;

  int   pass_cnt  = 0;
  int   total_cnt = 0;
  exp_t q[$];
  exp_t last      = '{0, 0, 0, 0};
  bit   mon_en    = 1'b0;
  bit   rand_rdy  = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    total_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  // Amount rules stated directly: rotates wrap at 8, shifts saturate at 8, others 0.
  function automatic int model_amt(input int typ, input int raw);
    if (typ == 0 || typ == 1) return raw % 8;
    if (typ >= 2 && typ <= 4) return (raw > 8) ? 8 : raw;
    return 0;
  endfunction

  task automatic cmp_out(input string name, input exp_t e);
    chk({name, ".sh_in"},     int'(bus.sh_in),     e.data);
    chk({name, ".sh_amount"}, int'(bus.sh_amount), e.amt);
    chk({name, ".sh_type"},   int'(bus.sh_type),   e.typ);
    chk({name, ".sh_tag"},    int'(bus.sh_tag),    e.tag);
  endtask

  // Scoreboard: checks the visible state each cycle, then applies this cycle's
  // flush/pop/push to the model exactly as the clock edge will.
  always @(negedge clk) begin
    exp_t e;
    int   raw;
    bit   full;
    if (mon_en) begin
      full = (q.size() >= DEPTH);
      chk("count",     int'(count),         q.size());
      chk("req_ready", int'(bus.req_ready), full ? 0 : 1);
      chk("sh_valid",  int'(bus.sh_valid),  (q.size() != 0) ? 1 : 0);
      if (q.size() != 0) cmp_out("head", q[0]);
      else               cmp_out("idle", last);
      if (flush) begin
        q.delete();
      end else begin
        if (q.size() != 0 && bus.sh_ready) last = q.pop_front();
        if (bus.req_valid && !full) begin
          raw    = bus.req_amt_sel ? int'(bus.req_amt_reg) : int'(bus.req_amt_imm);
          e.data = int'(bus.req_data);
          e.typ  = int'(bus.req_type);
          e.amt  = model_amt(e.typ, raw);
          e.tag  = int'(bus.req_tag);
          q.push_back(e);
        end
      end
    end
  end

  task automatic set_req(input logic [7:0] d, input logic [2:0] t, input logic sel,
                         input logic [4:0] imm, input logic [7:0] rg, input logic [2:0] tag);
    bus.req_valid   = 1'b1;
    bus.req_data    = d;
    bus.req_type    = t;
    bus.req_amt_sel = sel;
    bus.req_amt_imm = imm;
    bus.req_amt_reg = rg;
    bus.req_tag     = tag;
  endtask

  task automatic idle_in();
    bus.req_valid = 1'b0;
  endtask

  // Presents a request until accepted; returns just after the accepting edge.
  task automatic send(input logic [7:0] d, input logic [2:0] t, input logic sel,
                      input logic [4:0] imm, input logic [7:0] rg, input logic [2:0] tag);
    bit acc = 1'b0;
    set_req(d, t, sel, imm, rg, tag);
    for (int n = 0; n < 50 && !acc; n++) begin
      if (rand_rdy) bus.sh_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      acc = bus.req_ready;
      @(posedge clk);
      #1;
    end
    if (!acc) chk("send_timeout", 0, 1);
  endtask

  task automatic wait_empty();
    bit done = 1'b0;
    for (int n = 0; n < 100 && !done; n++) begin
      @(negedge clk);
      done = (q.size() == 0);
    end
    if (!done) chk("drain_timeout", 0, 1);
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_state(input string name);
    chk({name, ".count"},     int'(count),         0);
    chk({name, ".sh_valid"},  int'(bus.sh_valid),  0);
    chk({name, ".req_ready"}, int'(bus.req_ready), 0);
    cmp_out(name, '{0, 0, 0, 0});
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    idle_in();
    bus.req_data = '0; bus.req_type = '0; bus.req_amt_sel = 1'b0;
    bus.req_amt_imm = '0; bus.req_amt_reg = '0; bus.req_tag = '0;
    bus.sh_ready = 1'b0;
    #2;
    chk_reset_state("por");
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(posedge clk);
    #1 mon_en = 1'b1;

    // Normalisation cases
    bus.sh_ready = 1'b1;
    send(8'h11, 3'b001, 1'b1, 5'd0,  8'd13,  3'd1);
    send(8'h22, 3'b011, 1'b0, 5'd20, 8'd0,   3'd2);
    send(8'h33, 3'b010, 1'b1, 5'd0,  8'hFF,  3'd3);
    send(8'h44, 3'b110, 1'b0, 5'd9,  8'd0,   3'd4);
    idle_in();
    wait_empty();

    // Back-to-back with the consumer always ready
    send(8'hA5, 3'b000, 1'b0, 5'd1, 8'd0, 3'd5);
    send(8'h3C, 3'b100, 1'b0, 5'd2, 8'd0, 3'd6);
    send(8'h81, 3'b010, 1'b0, 5'd3, 8'd0, 3'd7);
    idle_in();
    wait_empty();

    // Full buffer and backpressure
    bus.sh_ready = 1'b0;
    send(8'h5A, 3'b011, 1'b0, 5'd4, 8'd0, 3'd0);
    send(8'h6B, 3'b001, 1'b1, 5'd0, 8'd30, 3'd1);
    set_req(8'h7C, 3'b100, 1'b1, 5'd0, 8'd7, 3'd2);
    repeat (3) @(posedge clk);
    #1 bus.sh_ready = 1'b1;
    @(posedge clk);
    #1 bus.sh_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 idle_in();
    chk("full_refill_count", int'(count), 2);
    bus.sh_ready = 1'b1;
    wait_empty();

    // Wrap-around with random consumer readiness
    rand_rdy = 1'b1;
    for (int i = 0; i < 10; i++)
      send(8'($urandom), 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
           5'($urandom), 8'($urandom), 3'(i % 8));
    idle_in();
    rand_rdy = 1'b0;
    bus.sh_ready = 1'b1;
    wait_empty();

    // Flush with a simultaneous push and pop
    bus.sh_ready = 1'b0;
    send(8'h12, 3'b000, 1'b0, 5'd3, 8'd0, 3'd3);
    send(8'h34, 3'b011, 1'b0, 5'd5, 8'd0, 3'd4);
    flush = 1'b1;
    bus.sh_ready = 1'b1;
    set_req(8'hEE, 3'b001, 1'b0, 5'd2, 8'd0, 3'd7);
    @(posedge clk);
    #1 flush = 1'b0;
    idle_in();
    chk("flush_count",     int'(count),         0);
    chk("flush_sh_valid",  int'(bus.sh_valid),  0);
    chk("flush_req_ready", int'(bus.req_ready), 1);
    repeat (4) @(posedge clk);
    #1;

    // Reset in the middle of operation
    bus.sh_ready = 1'b0;
    send(8'h9A, 3'b100, 1'b0, 5'd6, 8'd0, 3'd5);
    send(8'hBC, 3'b010, 1'b1, 5'd0, 8'd200, 3'd6);
    idle_in();
    mon_en = 1'b0;
    chk("pre_reset_count", int'(count), 2);
    #2 reset = 1'b1;
    #1 chk_reset_state("mid_reset");
    q.delete();
    last = '{0, 0, 0, 0};
    @(posedge clk);
    #1 reset = 1'b0;
    @(posedge clk);
    #1 chk("post_reset_req_ready", int'(bus.req_ready), 1);
    mon_en = 1'b1;
    bus.sh_ready = 1'b1;
    send(8'h0F, 3'b001, 1'b1, 5'd0, 8'd9, 3'd2);
    idle_in();
    wait_empty();

    repeat (3) @(posedge clk);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
